dsp_post_adder_acc: RTL and testbench

//   Post-adder/accumulator stage of the DSP48A1 slice model. Sits directly downstream of the

---
 rtl/dsp_post_adder_acc.sv | 150 +++++++++++++++
 tb/tb_dsp_post_adder_acc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dsp_post_adder_acc.sv
`default_nettype none
// ============================================================================
// Module  : dsp_post_adder_acc
// Brief   : DSP slice post-adder/accumulator with X/Z operand muxes, carry-in
//           and a 48-bit P accumulator that drives the cascade output.
// Revision: 1.0 - initial release
// ============================================================================
module dsp_post_adder_acc #(
    parameter int MREG       = 1,
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1,
    parameter int PREG       = 1,
    parameter     CARRYINSEL = "OPMODE5"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_m,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        ce_p,
    input  logic [7:0]  opmode,
    input  logic [35:0] m,
    input  logic [47:0] dab,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic        carryin,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carryoutf
);

    logic [35:0] w_m;
    logic [7:0]  w_opmode;
    logic        w_cin_raw;
    logic        w_cin;
    logic [47:0] w_x;
    logic [47:0] w_z;
    logic [48:0] w_xc;
    logic [48:0] w_sum;
    logic [47:0] r_p;
    logic        r_cout;

    generate
        if (MREG == 1) begin : g_mreg
            logic [35:0] r_m;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_m <= '0;
                else if (ce_m)
                    r_m <= m;
            end
            assign w_m = r_m;
        end else begin : g_mcomb
            assign w_m = m;
        end

        if (OPMODEREG == 1) begin : g_opreg
            logic [7:0] r_opmode;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_opmode <= '0;
                else if (ce_opmode)
                    r_opmode <= opmode;
            end
            assign w_opmode = r_opmode;
        end else begin : g_opcomb
            assign w_opmode = opmode;
        end

        // An unrecognised carry-in source ties carry-in low rather than guessing.
        if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
            assign w_cin_raw = opmode[5];
        end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
            assign w_cin_raw = carryin;
        end else begin : g_cin_none
            assign w_cin_raw = 1'b0;
        end

        if (CARRYINREG == 1) begin : g_cinreg
            logic r_cin;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_cin <= 1'b0;
                else if (ce_carryin)
                    r_cin <= w_cin_raw;
            end
            assign w_cin = r_cin;
        end else begin : g_cincomb
            assign w_cin = w_cin_raw;
        end
    endgenerate

    always_comb begin
        w_x = '0;
        case (w_opmode[1:0])
            2'd0: w_x = '0;
            2'd1: w_x = {{12{w_m[35]}}, w_m};
            2'd2: w_x = r_p;
            2'd3: w_x = dab;
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_opmode[3:2])
            2'd0: w_z = '0;
            2'd1: w_z = pcin;
            2'd2: w_z = r_p;
            2'd3: w_z = c;
            default: w_z = '0;
        endcase
    end

    // 49-bit arithmetic: bit 48 is carry on add and borrow on subtract.
    assign w_xc  = {1'b0, w_x} + {48'd0, w_cin};
    assign w_sum = w_opmode[7] ? ({1'b0, w_z} - w_xc) : ({1'b0, w_z} + w_xc);

    // Feedback always comes from r_p, so it exists whatever PREG is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p    <= '0;
            r_cout <= 1'b0;
        end else if (ce_p) begin
            r_p    <= w_sum[47:0];
            r_cout <= w_sum[48];
        end
    end

    generate
        if (PREG == 1) begin : g_pout_reg
            assign p        = r_p;
            assign carryout = r_cout;
        end else begin : g_pout_comb
            assign p        = rst ? w_sum[47:0] : 48'd0;
            assign carryout = rst ? w_sum[48] : 1'b0;
        end
    endgenerate

    assign pcout     = p;
    assign carryoutf = carryout;

    // Inputs that some parameter settings leave unused.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_opmode[6], w_opmode[4], opmode[5], carryin,
                           ce_m, ce_opmode, ce_carryin, w_cin_raw};

endmodule
`default_nettype wire

// File: tb/tb_dsp_post_adder_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_dsp_post_adder_acc
// Brief   : Directed self-checking bench for dsp_post_adder_acc (default params).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dsp_post_adder_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_m, ce_opmode, ce_carryin, ce_p;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic        carryin;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    int tests = 0;
    int fails = 0;

    dsp_post_adder_acc dut (
        .clk        (clk),
        .rst        (rst),
        .ce_m       (ce_m),
        .ce_opmode  (ce_opmode),
        .ce_carryin (ce_carryin),
        .ce_p       (ce_p),
        .opmode     (opmode),
        .m          (m),
        .dab        (dab),
        .c          (c),
        .pcin       (pcin),
        .carryin    (carryin),
        .p          (p),
        .pcout      (pcout),
        .carryout   (carryout),
        .carryoutf  (carryoutf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_p(input string tag, input logic [47:0] ep, input logic ec);
        check({tag, ".p"}, {1'b0, p}, {1'b0, ep});
        check({tag, ".pcout"}, {1'b0, pcout}, {1'b0, ep});
        check({tag, ".cout"}, {48'd0, carryout}, {48'd0, ec});
        check({tag, ".coutf"}, {48'd0, carryoutf}, {48'd0, ec});
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        ce_m = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
        opmode = 8'h01; m = 36'h1; dab = '0; c = '0; pcin = '0; carryin = 1'b0;

        // Reset and first pass-through of M
        tick(1);
        rst = 1'b0;
        #1;
        check_p("reset", 48'd0, 1'b0);
        tick(2);
        check_p("reset_held", 48'd0, 1'b0);
        rst = 1'b1;
        tick(1);
        check_p("m_lat1", 48'd0, 1'b0);
        tick(1);
        check_p("m_lat2", 48'd1, 1'b0);

        // MAC: P += M
        pulse_rst();
        check_p("mac_rst", 48'd0, 1'b0);
        opmode = 8'h09; m = 36'd5;
        tick(1);
        check_p("mac_fill", 48'd0, 1'b0);
        tick(1); check_p("mac5", 48'd5, 1'b0);
        tick(1); check_p("mac10", 48'd10, 1'b0);
        tick(1); check_p("mac15", 48'd15, 1'b0);
        tick(1); check_p("mac20", 48'd20, 1'b0);

        // Hold with ce_p low, then reset mid-accumulation
        ce_p = 1'b0;
        tick(1); check_p("hold1", 48'd20, 1'b0);
        tick(1); check_p("hold2", 48'd20, 1'b0);
        tick(1); check_p("hold3", 48'd20, 1'b0);
        ce_p = 1'b1;
        pulse_rst();
        check_p("midrst", 48'd0, 1'b0);
        tick(1); check_p("resume0", 48'd0, 1'b0);
        tick(1); check_p("resume5", 48'd5, 1'b0);
        tick(1); check_p("resume10", 48'd10, 1'b0);

        // Wrap with carry out
        pulse_rst();
        opmode = 8'h0F; dab = 48'hFFFF_FFFF_FFFF; c = 48'd1;
        tick(1); check_p("wrap_fill", 48'd0, 1'b0);
        tick(1); check_p("wrap", 48'd0, 1'b1);

        // Subtract, without and with carry-in, and with borrow
        opmode = 8'h8F; c = 48'd10; dab = 48'd3;
        tick(2); check_p("sub", 48'd7, 1'b0);
        opmode = 8'hAF;
        tick(1); check_p("sub_cin_lat", 48'd7, 1'b0);
        tick(1); check_p("sub_cin", 48'd6, 1'b0);
        opmode = 8'h8F; c = 48'd3; dab = 48'd10;
        tick(2); check_p("borrow", 48'hFFFF_FFFF_FFF9, 1'b1);

        // Sign extension of M
        opmode = 8'h01; m = 36'hF_FFFF_FFFF;
        tick(2); check_p("sext", 48'hFFFF_FFFF_FFFF, 1'b0);

        // X = Z = P doubles the accumulator
        opmode = 8'h0A;
        tick(1); check_p("dbl_lat", 48'hFFFF_FFFF_FFFF, 1'b0);
        tick(1); check_p("dbl1", 48'hFFFF_FFFF_FFFE, 1'b1);
        tick(1); check_p("dbl2", 48'hFFFF_FFFF_FFFC, 1'b1);

        // Cascade input plus M
        opmode = 8'h05; m = 36'd7; pcin = 48'd100;
        tick(2); check_p("pcin", 48'd107, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
